// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: control-register indices,
// MEM-stage control opcodes, ISA exception codes, STATUS layout and modes.
package pipe_ctrl_pkg;

   localparam int WORD_ADDR_W = 30;
   localparam int WORD_DATA_W = 32;
   localparam int REG_ADDR_W  = 5;

   // Control-register file indices (7..31 are unimplemented and read 0)
   localparam logic [REG_ADDR_W-1:0] CREG_STATUS     = 5'd0;
   localparam logic [REG_ADDR_W-1:0] CREG_PRE_STATUS = 5'd1;
   localparam logic [REG_ADDR_W-1:0] CREG_EPC        = 5'd2;
   localparam logic [REG_ADDR_W-1:0] CREG_EXP_VECTOR = 5'd3;
   localparam logic [REG_ADDR_W-1:0] CREG_CAUSE      = 5'd4;
   localparam logic [REG_ADDR_W-1:0] CREG_INT_MASK   = 5'd5;
   localparam logic [REG_ADDR_W-1:0] CREG_IRQ_PEND   = 5'd6;

   // STATUS bit positions
   localparam int STATUS_MODE_BIT = 0;
   localparam int STATUS_IE_BIT   = 1;

   typedef enum logic [1:0] {
      CTRL_OP_NOP  = 2'd0,
      CTRL_OP_WRCR = 2'd1,
      CTRL_OP_EXRT = 2'd2
   } ctrl_op_e;

   typedef enum logic [2:0] {
      ISA_EXP_NONE     = 3'd0,
      ISA_EXP_EXT_INT  = 3'd1,
      ISA_EXP_UNDEF    = 3'd2,
      ISA_EXP_OVERFLOW = 3'd3,
      ISA_EXP_MISALIGN = 3'd4,
      ISA_EXP_TRAP     = 3'd5,
      ISA_EXP_PRIV     = 3'd6
   } isa_exp_e;

   typedef enum logic {
      EXE_MODE_KERNEL = 1'b0,
      EXE_MODE_USER   = 1'b1
   } exe_mode_e;

   // Event committed from the MEM-stage register this cycle
   typedef enum logic [2:0] {
      COMMIT_NONE,
      COMMIT_EXP,
      COMMIT_IRQ,
      COMMIT_EXRT,
      COMMIT_WRCR
   } commit_e;

endpackage

// File: rtl/pipe_ctrl_irq_sync.sv
// Two-flop synchronizer for the external interrupt lines, followed by the
// INT_MASK gate (mask bit 1 = line masked).
module pipe_ctrl_irq_sync #(
   parameter int IRQ_CH = 8
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic [IRQ_CH-1:0] irq,
   input  logic [IRQ_CH-1:0] int_mask,
   output logic [IRQ_CH-1:0] pending
);

   logic [IRQ_CH-1:0] meta_q, meta_d;
   logic [IRQ_CH-1:0] sync_q, sync_d;

   // Shift the raw request through the two synchronizer stages
   always_comb begin
      meta_d = irq;
      sync_d = meta_q;
   end

   // Synchronizer flops, cleared by reset
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         // NOTE: non-blocking (<=) so both stages sample pre-edge values; blocking would collapse the chain to one flop.
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign pending = sync_q & ~int_mask;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage core: per-stage stall/flush, the
// control-register file, and commit of exceptions, interrupts, EXRT and WRCR
// from the MEM-stage register with fetch redirection through NewPC.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int          IRQ_CH         = 8,
   parameter logic [29:0] EXP_VECTOR_RST = 30'h0
) (
   input  logic                   clk,
   input  logic                   reset_,
   input  logic                   LDHazard,
   input  logic                   IFBusy,
   input  logic                   MemBusy,
   input  logic                   MemEn,
   input  logic [WORD_ADDR_W-1:0] MemPC,
   input  logic [1:0]             MemCtrlOp,
   input  logic [REG_ADDR_W-1:0]  MemDstAddr,
   input  logic [WORD_DATA_W-1:0] MemWrData,
   input  logic [2:0]             MemExpCode,
   input  logic [IRQ_CH-1:0]      Irq,
   input  logic [REG_ADDR_W-1:0]  CRegRdAddr,
   output logic [WORD_DATA_W-1:0] CRegRdData,
   output logic                   ExeMode,
   output logic                   IFStall,
   output logic                   IDStall,
   output logic                   EXStall,
   output logic                   MemStall,
   output logic                   IFFlush,
   output logic                   IDFlush,
   output logic                   EXFlush,
   output logic                   MemFlush,
   output logic [WORD_ADDR_W-1:0] NewPC
);

   // Control-register file
   logic [1:0]             status_q,     status_d;
   logic [1:0]             pre_status_q, pre_status_d;
   logic [WORD_ADDR_W-1:0] epc_q,        epc_d;
   logic [WORD_ADDR_W-1:0] exp_vector_q, exp_vector_d;
   logic [2:0]             cause_q,      cause_d;
   logic [IRQ_CH-1:0]      int_mask_q,   int_mask_d;

   logic              busy;
   logic [IRQ_CH-1:0] irq_pending;
   commit_e           commit;

   pipe_ctrl_irq_sync #(
      .IRQ_CH (IRQ_CH)
   ) u_irq_sync (
      .clk      (clk),
      .reset_   (reset_),
      .irq      (Irq),
      .int_mask (int_mask_q),
      .pending  (irq_pending)
   );

   assign busy     = IFBusy | MemBusy;
   assign IFStall  = busy | LDHazard;
   assign IDStall  = busy;
   assign EXStall  = busy;
   assign MemStall = busy;
   assign ExeMode  = status_q[STATUS_MODE_BIT];

   // Pick the highest-priority event committing from MEM this cycle
   always_comb begin
      // NOTE: every signal of an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
      commit = COMMIT_NONE;
      if (MemEn && !busy) begin
         if (MemExpCode != ISA_EXP_NONE) begin
            commit = COMMIT_EXP;
         end else if (status_q[STATUS_IE_BIT] && (|irq_pending)) begin
            commit = COMMIT_IRQ;
         end else if (MemCtrlOp == CTRL_OP_EXRT) begin
            commit = COMMIT_EXRT;
         end else if (MemCtrlOp == CTRL_OP_WRCR) begin
            commit = COMMIT_WRCR;
         end
      end
   end

   // Next creg state, redirect target and flush pattern for the chosen event
   always_comb begin
      status_d     = status_q;
      pre_status_d = pre_status_q;
      epc_d        = epc_q;
      exp_vector_d = exp_vector_q;
      cause_d      = cause_q;
      int_mask_d   = int_mask_q;
      NewPC        = '0;
      IFFlush      = 1'b0;
      IDFlush      = LDHazard & ~busy;
      EXFlush      = 1'b0;
      MemFlush     = 1'b0;

      if (commit != COMMIT_NONE) begin
         IFFlush  = 1'b1;
         IDFlush  = 1'b1;
         EXFlush  = 1'b1;
         MemFlush = 1'b1;
      end

      case (commit)
         COMMIT_EXP, COMMIT_IRQ: begin
            NewPC        = exp_vector_q;
            pre_status_d = status_q;
            status_d     = 2'b00;
            epc_d        = MemPC;
            if (commit == COMMIT_IRQ) begin
               cause_d = ISA_EXP_EXT_INT;
            end else begin
               cause_d = MemExpCode;
            end
         end
         COMMIT_EXRT: begin
            NewPC    = epc_q;
            status_d = pre_status_q;
         end
         COMMIT_WRCR: begin
            // Refetch the next instruction under the new mode/mask
            NewPC = WORD_ADDR_W'(MemPC + 30'd1);
            case (MemDstAddr)
               CREG_STATUS:     status_d     = MemWrData[1:0];
               CREG_PRE_STATUS: pre_status_d = MemWrData[1:0];
               CREG_EPC:        epc_d        = MemWrData[31:2];
               CREG_EXP_VECTOR: exp_vector_d = MemWrData[31:2];
               CREG_CAUSE:      cause_d      = MemWrData[2:0];
               CREG_INT_MASK:   int_mask_d   = MemWrData[IRQ_CH-1:0];
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // Combinational creg read port for ID; a same-cycle WRCR is not bypassed
   always_comb begin
      CRegRdData = '0;
      case (CRegRdAddr)
         CREG_STATUS:     CRegRdData[1:0]        = status_q;
         CREG_PRE_STATUS: CRegRdData[1:0]        = pre_status_q;
         CREG_EPC:        CRegRdData[31:2]       = epc_q;
         CREG_EXP_VECTOR: CRegRdData[31:2]       = exp_vector_q;
         CREG_CAUSE:      CRegRdData[2:0]        = cause_q;
         CREG_INT_MASK:   CRegRdData[IRQ_CH-1:0] = int_mask_q;
         CREG_IRQ_PEND:   CRegRdData[IRQ_CH-1:0] = irq_pending;
         default: ;
      endcase
   end

   // Creg state registers; reset drops any commit in flight
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         // NOTE: the creg file is a handful of discrete flops, so every entry is reset (unlike a RAM array).
         status_q     <= 2'b00;
         pre_status_q <= 2'b00;
         epc_q        <= '0;
         exp_vector_q <= EXP_VECTOR_RST;
         cause_q      <= '0;
         int_mask_q   <= '1;
      end else begin
         status_q     <= status_d;
         pre_status_q <= pre_status_d;
         epc_q        <= epc_d;
         exp_vector_q <= exp_vector_d;
         cause_q      <= cause_d;
         int_mask_q   <= int_mask_d;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run,
// all compared against a behavioural model of the control-register file.
module tb_pipe_ctrl;

   localparam int          IRQ_CH  = 8;
   localparam logic [29:0] VEC_RST = 30'h40;
   localparam int K_NONE = 0, K_EXC = 1, K_IRQ = 2, K_EXRT = 3, K_WRCR = 4;

   logic        clk = 1'b0;
   logic        reset_;
   logic        LDHazard, IFBusy, MemBusy, MemEn;
   logic [29:0] MemPC;
   logic [1:0]  MemCtrlOp;
   logic [4:0]  MemDstAddr;
   logic [31:0] MemWrData;
   logic [2:0]  MemExpCode;
   logic [7:0]  Irq;
   logic [4:0]  CRegRdAddr;
   logic [31:0] CRegRdData;
   logic        ExeMode;
   logic        IFStall, IDStall, EXStall, MemStall;
   logic        IFFlush, IDFlush, EXFlush, MemFlush;
   logic [29:0] NewPC;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   logic [1:0]  m_status, m_pre;
   logic [29:0] m_epc, m_vec;
   logic [2:0]  m_cause;
   logic [7:0]  m_mask;
   logic [7:0]  irq_hist[$];   // Irq samples at past edges, oldest first

   always #5 clk = ~clk;

   pipe_ctrl #(
      .IRQ_CH         (IRQ_CH),
      .EXP_VECTOR_RST (VEC_RST)
   ) dut (
      .clk        (clk),
      .reset_     (reset_),
      .LDHazard   (LDHazard),
      .IFBusy     (IFBusy),
      .MemBusy    (MemBusy),
      .MemEn      (MemEn),
      .MemPC      (MemPC),
      .MemCtrlOp  (MemCtrlOp),
      .MemDstAddr (MemDstAddr),
      .MemWrData  (MemWrData),
      .MemExpCode (MemExpCode),
      .Irq        (Irq),
      .CRegRdAddr (CRegRdAddr),
      .CRegRdData (CRegRdData),
      .ExeMode    (ExeMode),
      .IFStall    (IFStall),
      .IDStall    (IDStall),
      .EXStall    (EXStall),
      .MemStall   (MemStall),
      .IFFlush    (IFFlush),
      .IDFlush    (IDFlush),
      .EXFlush    (EXFlush),
      .MemFlush   (MemFlush),
      .NewPC      (NewPC)
   );

   // ---------------- model ----------------
   task automatic model_reset();
      m_status = 2'b00; m_pre = 2'b00; m_epc = '0; m_vec = VEC_RST;
      m_cause = '0; m_mask = 8'hFF;
      irq_hist.delete();
      irq_hist.push_back(8'h00);
      irq_hist.push_back(8'h00);
   endtask

   // Interrupts visible now were sampled two edges ago
   function automatic logic [7:0] m_pending();
      return irq_hist[0] & ~m_mask;
   endfunction

   function automatic int model_kind();
      if (!MemEn || IFBusy || MemBusy) return K_NONE;
      if (MemExpCode != 3'd0) return K_EXC;
      if (m_status[1] && (m_pending() != 8'h00)) return K_IRQ;
      if (MemCtrlOp == 2'd2) return K_EXRT;
      if (MemCtrlOp == 2'd1) return K_WRCR;
      return K_NONE;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] a);
      case (a)
         5'd0:    return {30'd0, m_status};
         5'd1:    return {30'd0, m_pre};
         5'd2:    return {m_epc, 2'b00};
         5'd3:    return {m_vec, 2'b00};
         5'd4:    return {29'd0, m_cause};
         5'd5:    return {24'd0, m_mask};
         5'd6:    return {24'd0, m_pending()};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step();
      int k;
      k = model_kind();
      if (k == K_EXC || k == K_IRQ) begin
         m_pre    = m_status;
         m_status = 2'b00;
         m_epc    = MemPC;
         m_cause  = (k == K_IRQ) ? 3'd1 : MemExpCode;
      end else if (k == K_EXRT) begin
         m_status = m_pre;
      end else if (k == K_WRCR) begin
         case (MemDstAddr)
            5'd0: m_status = MemWrData[1:0];
            5'd1: m_pre    = MemWrData[1:0];
            5'd2: m_epc    = MemWrData[31:2];
            5'd3: m_vec    = MemWrData[31:2];
            5'd4: m_cause  = MemWrData[2:0];
            5'd5: m_mask   = MemWrData[7:0];
            default: ;
         endcase
      end
      irq_hist.push_back(Irq);
      void'(irq_hist.pop_front());
   endtask

   // {stalls IF..MEM, flushes IF..MEM, NewPC, ExeMode, CRegRdData}
   function automatic logic [70:0] exp_vec();
      logic        busy;
      int          k;
      logic [3:0]  fl;
      logic [29:0] npc;
      busy = IFBusy | MemBusy;
      k    = model_kind();
      fl   = (k != K_NONE) ? 4'hF : {1'b0, LDHazard & ~busy, 2'b00};
      case (k)
         K_EXC, K_IRQ: npc = m_vec;
         K_EXRT:       npc = m_epc;
         K_WRCR:       npc = MemPC + 30'd1;
         default:      npc = 30'd0;
      endcase
      return {busy | LDHazard, busy, busy, busy, fl, npc, m_status[0], model_read(CRegRdAddr)};
   endfunction

   function automatic logic [70:0] obs_vec();
      return {IFStall, IDStall, EXStall, MemStall, IFFlush, IDFlush, EXFlush, MemFlush,
              NewPC, ExeMode, CRegRdData};
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic idle();
      LDHazard = 0; IFBusy = 0; MemBusy = 0; MemEn = 0; MemPC = '0;
      MemCtrlOp = 2'd0; MemDstAddr = '0; MemWrData = '0; MemExpCode = 3'd0;
      CRegRdAddr = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset_) model_reset();
      else model_step();
      #1;
   endtask

   task automatic wrcr(input logic [4:0] a, input logic [31:0] d);
      idle();
      MemEn = 1; MemCtrlOp = 2'd1; MemDstAddr = a; MemWrData = d; MemPC = 30'h10;
      tick();
      idle();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [4:0]  addrs[3];
      logic [31:0] want[3];
      addrs = '{5'd0, 5'd5, 5'd3};
      want  = '{32'd0, 32'h0000_00FF, {VEC_RST, 2'b00}};
      idle(); Irq = '0; reset_ = 0; model_reset();
      #1;
      for (int i = 0; i < 3; i++) begin
         CRegRdAddr = addrs[i];
         @(negedge clk);
         checks++;
         if (CRegRdData !== want[i] || obs_vec()[70:32] !== 39'd0) begin
            errors++;
            $display("FAIL reset_state[%0d]: got rd=%h ctl=%h want rd=%h ctl=0", i, CRegRdData, obs_vec()[70:32], want[i]);
         end
         tick();
      end
      reset_ = 1;
   endtask

   task automatic test_hazard();
      logic [2:0] stim[5];
      logic [7:0] want[5];
      stim = '{3'b100, 3'b101, 3'b010, 3'b110, 3'b000};   // {LDHazard, IFBusy, MemBusy}
      want = '{8'b1000_0100, 8'b1111_0000, 8'b1111_0000, 8'b1111_0000, 8'b0000_0000};
      for (int i = 0; i < 5; i++) begin
         idle();
         {LDHazard, IFBusy, MemBusy} = stim[i];
         @(negedge clk);
         checks++;
         if (obs_vec()[70:63] !== want[i]) begin
            errors++;
            $display("FAIL hazard[%0d]: got stall/flush=%b want %b", i, obs_vec()[70:63], want[i]);
         end
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL hazard_model[%0d]: got %h want %h", i, obs_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_wrcr();
      // Write STATUS=user mode at the top of the PC space; old value still readable
      idle();
      MemEn = 1; MemCtrlOp = 2'd1; MemDstAddr = 5'd0; MemWrData = 32'h1; MemPC = 30'h3FFF_FFFF;
      CRegRdAddr = 5'd0;
      @(negedge clk);
      checks++;
      if (NewPC !== 30'd0 || {IFFlush, IDFlush, EXFlush, MemFlush} !== 4'hF || CRegRdData !== 32'd0) begin
         errors++;
         $display("FAIL wrcr_wrap: got npc=%h fl=%b rd=%h want npc=0 fl=1111 rd=0", NewPC,
                  {IFFlush, IDFlush, EXFlush, MemFlush}, CRegRdData);
      end
      tick();
      // Writes to the read-only pending register and to an unimplemented index are dropped
      MemDstAddr = 5'd6; MemWrData = 32'hFFFF_FFFF; MemPC = 30'h20;
      tick();
      MemDstAddr = 5'd9;
      tick();
      idle();
      for (int a = 0; a < 10; a += 3) begin
         CRegRdAddr = 5'(a);
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL wrcr_read[%0d]: got %h want %h", a, obs_vec(), exp_vec());
         end
         tick();
      end
      checks++;
      if (ExeMode !== 1'b1) begin
         errors++;
         $display("FAIL wrcr_mode: got ExeMode=%b want 1", ExeMode);
      end
   endtask

   task automatic test_exception();
      logic [4:0]  addrs[4];
      logic [31:0] want[4];
      addrs = '{5'd2, 5'd4, 5'd0, 5'd1};
      want  = '{32'h0000_0400, 32'd3, 32'd0, 32'd1};
      idle();
      MemEn = 1; MemExpCode = 3'd3; MemPC = 30'h100;
      @(negedge clk);
      checks++;
      if (NewPC !== 30'h40 || {IFFlush, IDFlush, EXFlush, MemFlush} !== 4'hF) begin
         errors++;
         $display("FAIL exc_flush: got npc=%h fl=%b want npc=40 fl=1111", NewPC, {IFFlush, IDFlush, EXFlush, MemFlush});
      end
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         CRegRdAddr = addrs[i];
         @(negedge clk);
         checks++;
         if (CRegRdData !== want[i] || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL exc_state[%0d]: got %h want %h", i, CRegRdData, want[i]);
         end
         tick();
      end
   endtask

   task automatic test_irq();
      wrcr(5'd5, 32'h0);
      wrcr(5'd0, 32'h2);
      // IE=1: Irq[2] held for three cycles is taken in the third
      for (int i = 0; i < 3; i++) begin
         idle();
         MemEn = 1; MemPC = 30'h300 + 30'(i); Irq = 8'h04;
         @(negedge clk);
         checks++;
         if (IFFlush !== (i == 2) || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL irq_take[%0d]: got flush=%b %h want flush=%b %h", i, IFFlush, obs_vec(), (i == 2), exp_vec());
         end
         tick();
      end
      Irq = 8'h00;
      idle();
      CRegRdAddr = 5'd2;
      @(negedge clk);
      checks++;
      if (CRegRdData !== {30'h302, 2'b00}) begin
         errors++;
         $display("FAIL irq_epc: got %h want %h", CRegRdData, {30'h302, 2'b00});
      end
      tick();
      CRegRdAddr = 5'd4;
      @(negedge clk);
      checks++;
      if (CRegRdData !== 32'd1) begin
         errors++;
         $display("FAIL irq_cause: got %h want 1", CRegRdData);
      end
      tick();
      repeat (2) tick();
      // IE now 0: the same pulse must not be taken, but shows up as pending
      for (int i = 0; i < 5; i++) begin
         idle();
         MemEn = 1; MemPC = 30'h400 + 30'(i); CRegRdAddr = 5'd6;
         Irq = (i < 3) ? 8'h04 : 8'h00;
         @(negedge clk);
         checks++;
         if (IFFlush !== 1'b0 || (i == 2 && CRegRdData !== 32'h4) || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL irq_masked[%0d]: got %h want %h", i, obs_vec(), exp_vec());
         end
         tick();
      end
      idle();
      repeat (3) tick();
   endtask

   task automatic test_exrt();
      wrcr(5'd1, 32'h3);
      wrcr(5'd2, 32'h0000_0800);
      MemEn = 1; MemCtrlOp = 2'd2; MemPC = 30'h55;
      @(negedge clk);
      checks++;
      if (NewPC !== 30'h200 || MemFlush !== 1'b1) begin
         errors++;
         $display("FAIL exrt_pc: got npc=%h fl=%b want npc=200 fl=1", NewPC, MemFlush);
      end
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (ExeMode !== 1'b1 || CRegRdData !== 32'd3) begin
         errors++;
         $display("FAIL exrt_status: got mode=%b status=%h want mode=1 status=3", ExeMode, CRegRdData);
      end
      tick();
      // EXRT from user mode arrives tagged as privilege violation
      MemEn = 1; MemCtrlOp = 2'd2; MemExpCode = 3'd6; MemPC = 30'h66;
      @(negedge clk);
      checks++;
      if (NewPC !== 30'h40 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL exrt_user: got %h want %h", obs_vec(), exp_vec());
      end
      tick();
      idle();
      CRegRdAddr = 5'd4;
      @(negedge clk);
      checks++;
      if (CRegRdData !== 32'd6 || ExeMode !== 1'b0) begin
         errors++;
         $display("FAIL exrt_user_cause: got cause=%h mode=%b want cause=6 mode=0", CRegRdData, ExeMode);
      end
      tick();
   endtask

   task automatic test_priority();
      wrcr(5'd0, 32'h2);
      Irq = 8'h20;
      // Pending interrupt waits for a valid MEM instruction
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (MemFlush !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL prio_wait_en[%0d]: got %h want %h", i, obs_vec(), exp_vec());
         end
         tick();
      end
      // Exception + interrupt + WRCR, held off by MemBusy
      MemEn = 1; MemExpCode = 3'd4; MemCtrlOp = 2'd1; MemDstAddr = 5'd5;
      MemWrData = 32'hFFFF_FFFF; MemPC = 30'h77; MemBusy = 1; CRegRdAddr = 5'd4;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (MemFlush !== 1'b0 || MemStall !== 1'b1 || CRegRdData !== 32'd6) begin
            errors++;
            $display("FAIL prio_busy[%0d]: got fl=%b st=%b cause=%h want fl=0 st=1 cause=6", i, MemFlush, MemStall, CRegRdData);
         end
         tick();
      end
      MemBusy = 0;
      @(negedge clk);
      checks++;
      if (NewPC !== 30'h40 || MemFlush !== 1'b1 || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL prio_take: got %h want %h", obs_vec(), exp_vec());
      end
      tick();
      idle();
      Irq = 8'h00;
      CRegRdAddr = 5'd4;
      @(negedge clk);
      checks++;
      if (CRegRdData !== 32'd4) begin
         errors++;
         $display("FAIL prio_cause: got %h want 4", CRegRdData);
      end
      tick();
      CRegRdAddr = 5'd5;
      @(negedge clk);
      checks++;
      if (CRegRdData !== 32'd0) begin
         errors++;
         $display("FAIL prio_no_write: got mask=%h want 0", CRegRdData);
      end
      tick();
      repeat (2) tick();
   endtask

   task automatic test_reset_mid();
      idle();
      MemEn = 1; MemExpCode = 3'd5; MemPC = 30'h123;
      @(negedge clk);
      checks++;
      if (MemFlush !== 1'b1) begin
         errors++;
         $display("FAIL midrst_flush: got %b want 1", MemFlush);
      end
      #2;
      reset_ = 0;
      model_reset();
      tick();
      reset_ = 1;
      idle();
      for (int a = 1; a < 6; a++) begin
         CRegRdAddr = 5'(a);
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL midrst_state[%0d]: got %h want %h", a, obs_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_random();
      idle();
      for (int n = 0; n < 600; n++) begin
         LDHazard   = ($urandom_range(0, 3) == 0);
         IFBusy     = ($urandom_range(0, 7) == 0);
         MemBusy    = ($urandom_range(0, 7) == 0);
         MemEn      = ($urandom_range(0, 2) != 0);
         MemPC      = 30'($urandom);
         MemCtrlOp  = 2'($urandom_range(0, 3));
         MemDstAddr = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
         MemWrData  = $urandom;
         MemExpCode = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
         CRegRdAddr = 5'($urandom_range(0, 8));
         if ($urandom_range(0, 9) == 0) Irq = 8'($urandom);
         @(negedge clk);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random[%0d]: got %h want %h", n, obs_vec(), exp_vec());
         end
         tick();
      end
      idle();
      Irq = '0;
   endtask

   initial begin
      test_reset();
      test_hazard();
      test_wrcr();
      test_exception();
      test_irq();
      test_exrt();
      test_priority();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
